// File: rtl/seg_pkg.sv
// seg_pkg: shared codes, segment patterns and scan state type for the
// seven-segment scanner.
package seg_pkg;
    localparam logic [3:0] CODE_MINUS = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [6:0] SEG_MINUS  = 7'h3F;
    typedef enum logic [0:0] {S_BLANK, S_DRIVE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble code to active-low {g,f,e,d,c,b,a} pattern;
// digits 0-9, minus sign, everything else dark.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:       seg_o = 7'b1000000;
            4'd1:       seg_o = 7'b1111001;
            4'd2:       seg_o = 7'b0100100;
            4'd3:       seg_o = 7'b0110000;
            4'd4:       seg_o = 7'b0011001;
            4'd5:       seg_o = 7'b0010010;
            4'd6:       seg_o = 7'b0000010;
            4'd7:       seg_o = 7'b1111000;
            4'd8:       seg_o = 7'b0000000;
            4'd9:       seg_o = 7'b0010000;
            CODE_MINUS: seg_o = SEG_MINUS;
            default:    seg_o = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-buffered 4-digit common-anode scanner with dead-time
// blanking; define DISP_BLINK_EN to add the frame-rate blink input.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] signedBCD,
    input  logic        load,
`ifdef DISP_BLINK_EN
    input  logic        blink,
`endif
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        frameStart
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic          pend_q, pend_d;
    logic [3:0]    anode_d;
    logic [6:0]    seg_d, dec;
    logic          fs_d, tc, wrap, off;

    seg7_decode u_dec (.code_i(disp_q[{idx_q, 2'b00} +: 4]), .seg_o(dec));

`ifdef DISP_BLINK_EN
    localparam int FW = $clog2(2 * BLINK_FRAMES);
    logic [FW-1:0] fc_q, fc_d;
    always_comb begin
        fc_d = !blink ? '0 : !wrap ? fc_q : fc_q == FW'(2 * BLINK_FRAMES - 1) ? '0 : fc_q + 1'b1;
        off  = blink && fc_q >= FW'(BLINK_FRAMES);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fc_q <= '0;
        else       fc_q <= fc_d;
    end
`else
    assign off = 1'b0;
`endif

    always_comb begin
        tc       = cnt_q == CW'(SCAN_DIV - 1);
        wrap     = tc && idx_q == 2'd3;
        cnt_d    = tc ? '0 : cnt_q + 1'b1;
        idx_d    = tc ? idx_q + 2'd1 : idx_q;
        state_d  = cnt_d >= CW'(BLANK_CYCLES) ? S_DRIVE : S_BLANK;
        shadow_d = load ? signedBCD : shadow_q;
        // a load landing on the wrap edge goes straight to the display
        disp_d   = !wrap ? disp_q : load ? signedBCD : pend_q ? shadow_q : disp_q;
        pend_d   = !wrap && (load || pend_q);
        anode_d  = state_q == S_DRIVE && !off ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d    = state_q == S_DRIVE ? dec : SEG_OFF;
        fs_d     = cnt_q == '0 && idx_q == 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= S_BLANK;
            shadow_q   <= 16'hFFFF;
            disp_q     <= 16'hFFFF;
            pend_q     <= 1'b0;
            anode      <= 4'hF;
            segments   <= SEG_OFF;
            frameStart <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            anode      <= anode_d;
            segments   <= seg_d;
            frameStart <= fs_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed plus random loads against a frame-level model
// of the scanner (positions derived from elapsed cycles since reset).
module tb_seven_seg_scan;
    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] signedBCD = '0;
    logic        load = 1'b0;
    logic        blink = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        frameStart;

    int checks = 0;
    int failures = 0;
    int k = 0;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    int          m_fc;
    logic [6:0]  dec_tab [16];

    seven_seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .signedBCD(signedBCD), .load(load),
`ifdef DISP_BLINK_EN
        .blink(blink),
`endif
        .anode(anode), .segments(segments), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        k = 0;
        m_disp = 16'hFFFF;
        m_shadow = 16'hFFFF;
        m_pend = 1'b0;
        m_fc = 0;
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (anode === 4'hF) else begin failures++; $error("FAIL %s anode got=%b exp=1111", tag, anode); end
        checks++;
        assert (segments === 7'h7F) else begin failures++; $error("FAIL %s segments got=%b exp=1111111", tag, segments); end
        checks++;
        assert (frameStart === 1'b0) else begin failures++; $error("FAIL %s frameStart got=%b exp=0", tag, frameStart); end
    endtask

    // One clock: outputs after this edge reflect scan position p = k.
    task automatic step(input logic ld, input logic [15:0] d);
        int p, pos, slot;
        logic bnd, drive, blanked;
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        load = ld;
        signedBCD = d;
        p = k;
        pos = p % SD;
        slot = (p / SD) % 4;
        drive = pos >= BL;
`ifdef DISP_BLINK_EN
        blanked = blink && m_fc >= BF;
`else
        blanked = 1'b0;
`endif
        ea = drive && !blanked ? ~(4'b0001 << slot) : 4'hF;
        es = drive ? dec_tab[(m_disp >> (4 * slot)) & 16'hF] : 7'h7F;
        ef = (p % FRAME) == 0;
        bnd = (p % FRAME) == FRAME - 1;
        if (bnd) begin
            if (ld) m_disp = d;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 1'b0;
        end else if (ld) m_pend = 1'b1;
        if (ld) m_shadow = d;
        m_fc = !blink ? 0 : bnd ? (m_fc + 1) % (2 * BF) : m_fc;
        @(posedge clk);
        #1;
        k++;
        checks++;
        assert (anode === ea) else begin failures++; $error("FAIL anode p=%0d got=%b exp=%b", p, anode, ea); end
        checks++;
        assert (segments === es) else begin failures++; $error("FAIL segments p=%0d got=%b exp=%b", p, segments, es); end
        checks++;
        assert (frameStart === ef) else begin failures++; $error("FAIL frameStart p=%0d got=%b exp=%b", p, frameStart, ef); end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    initial begin
        dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                    7'h7F, 7'h7F, 7'b0111111, 7'h7F};
        #2 reset = 1'b1;
        @(posedge clk);
        #1 check_reset("reset_hold");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        run(FRAME);
        run(11);
        step(1'b1, 16'hF123);
        run(2 * FRAME);
        run(13);
        step(1'b1, 16'hFE05);
        run(2 * FRAME);
        while ((k % FRAME) != FRAME - 1) step(1'b0, 16'h0000);
        step(1'b1, 16'hE987);
        run(FRAME);
        step(1'b1, 16'h1111);
        step(1'b1, 16'h4321);
        run(FRAME + 4);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 11) == 0, 16'($urandom));
        step(1'b1, 16'h0864);
        run(FRAME);
`ifdef DISP_BLINK_EN
        while ((k % FRAME) != 0) step(1'b0, 16'h0000);
        blink = 1'b1;
        run(5 * FRAME);
        blink = 1'b0;
        run(2 * FRAME);
`endif
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((k - 1) % FRAME) / SD == 2 && ((k - 1) % SD) >= BL + 1) break;
            step(1'b0, 16'h0000);
        end
        #2 reset = 1'b1;
        #1 check_reset("reset_async");
        @(posedge clk);
        #1 check_reset("reset_held");
        reset = 1'b0;
        model_reset();
        run(FRAME + 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
